fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 24 ++
 rtl/fetch_unit.sv | 126 ++++++++++++
 tb/tb_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-cache request/response bus between the fetch unit and the I-cache.
// The fetch unit is the master; the cache answers combinationally on a hit.
interface fetch_unit_if #(
    parameter int unsigned LINE_WIDTH = 128
);
    logic [31:0]           cache_address;
    logic                  cache_enable;
    logic                  cache_ready;
    logic [LINE_WIDTH-1:0] cache_out_data;

    modport master (
        output cache_address,
        output cache_enable,
        input  cache_ready,
        input  cache_out_data
    );

    modport slave (
        input  cache_address,
        input  cache_enable,
        output cache_ready,
        output cache_out_data
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential PC, single-cycle I-cache lookup and an
// in-order fetch queue feeding decode, with redirect flush and misalignment trap.
module fetch_unit #(
    parameter int unsigned LINE_WIDTH  = 128,
    parameter int unsigned INSTR_WIDTH = 32,
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    fetch_unit_if.master           cache,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [31:0]            pc_out,
    output logic [31:0]            pcIncr,
    output logic [31:0]            pcJump,
    output logic                   instruction_valid,
    output logic                   misaligned_error
);

    localparam int unsigned WORDS   = LINE_WIDTH / INSTR_WIDTH;
    localparam int unsigned PTR_W   = $clog2(QUEUE_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(QUEUE_DEPTH);

    logic [31:0]            pc_q, pc_d;
    logic                   err_q, err_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]         count_q, count_d;
    logic [31:0]            pc_mem_q    [QUEUE_DEPTH];
    logic [31:0]            pc_mem_d    [QUEUE_DEPTH];
    logic [INSTR_WIDTH-1:0] instr_mem_q [QUEUE_DEPTH];
    logic [INSTR_WIDTH-1:0] instr_mem_d [QUEUE_DEPTH];

    logic [31:0]            word_idx;
    logic [INSTR_WIDTH-1:0] fetch_word;
    logic                   can_accept;
    logic                   fetch_en;
    logic                   push;
    logic                   pop;

    // Word offset within the line; a mux loop keeps LINE_WIDTH=32 (one word) legal.
    always_comb begin
        word_idx   = (pc_q >> 2) & (WORDS - 1);
        fetch_word = '0;
        for (int unsigned i = 0; i < WORDS; i++) begin
            if (word_idx == i) begin
                fetch_word = cache.cache_out_data[i*INSTR_WIDTH +: INSTR_WIDTH];
            end
        end
    end

    always_comb begin
        instruction_valid = (count_q != '0) && !reset;
        pop               = instruction_valid && !stall && !redirect_valid;
        can_accept        = (count_q < DEPTH_C) || pop;
        fetch_en          = can_accept && !err_q && (pc_q[1:0] == 2'b00)
                            && !redirect_valid && !reset;
        push              = fetch_en && cache.cache_ready;
    end

    assign cache.cache_address = pc_q;
    assign cache.cache_enable  = fetch_en;

    always_comb begin
        pc_d        = pc_q;
        err_d       = err_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;

        if (redirect_valid) begin
            // Flush wins over any push/pop; the cache response this cycle is dropped.
            pc_d     = redirect_pc;
            err_d    = (redirect_pc[1:0] != 2'b00);
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            err_d = err_q || (pc_q[1:0] != 2'b00);
            if (push) begin
                pc_mem_d[wr_ptr_q]    = pc_q;
                instr_mem_d[wr_ptr_q] = fetch_word;
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
                pc_d                  = pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + (PTR_W + 1)'(1);
                2'b01:   count_d = count_q - (PTR_W + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        pc_mem_q    <= pc_mem_d;
        instr_mem_q <= instr_mem_d;
    end

    assign instruction      = instr_mem_q[rd_ptr_q];
    assign pc_out           = pc_mem_q[rd_ptr_q];
    assign pcIncr           = pc_out + 32'd4;
    assign pcJump           = {pcIncr[31:28], instruction[25:0], 2'b00};
    assign misaligned_error = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational always-answering I-cache
// whose word at address A is 32'hC000_0000 ^ A (one special word at 32'h4000_0000).
module tb_fetch_unit;

    localparam int unsigned LW = 128;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic [31:0] pcIncr;
    logic [31:0] pcJump;
    logic        instruction_valid;
    logic        misaligned_error;
    logic [31:0] line_base;

    int passed;
    int total;

    fetch_unit_if #(.LINE_WIDTH(LW)) bus ();

    fetch_unit #(
        .LINE_WIDTH (LW),
        .INSTR_WIDTH(32),
        .QUEUE_DEPTH(4),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .stall            (stall),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .cache            (bus),
        .instruction      (instruction),
        .pc_out           (pc_out),
        .pcIncr           (pcIncr),
        .pcJump           (pcJump),
        .instruction_valid(instruction_valid),
        .misaligned_error (misaligned_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h4000_0000) return 32'h0800_0010;
        return 32'hC000_0000 ^ a;
    endfunction

    always_comb begin
        line_base          = bus.cache_address & ~32'(LW / 8 - 1);
        bus.cache_out_data = '0;
        for (int unsigned i = 0; i < LW / 32; i++) begin
            bus.cache_out_data[i*32 +: 32] = mem_word(line_base + 32'(i * 4));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        bus.cache_ready = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        bus.cache_ready = 1'b1;
        tick();
        tick();
        total++; if (instruction_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", instruction_valid); else passed++;
        total++; if (bus.cache_enable !== 1'b0) $display("FAIL reset_enable: got %b expected 0", bus.cache_enable); else passed++;
        total++; if (bus.cache_address !== 32'h0) $display("FAIL reset_addr: got %h expected 00000000", bus.cache_address); else passed++;
        total++; if (misaligned_error !== 1'b0) $display("FAIL reset_err: got %b expected 0", misaligned_error); else passed++;
        reset = 1'b0;
        #1;
        total++; if (bus.cache_enable !== 1'b1) $display("FAIL reset_release_enable: got %b expected 1", bus.cache_enable); else passed++;
    endtask

    task automatic test_sequential();
        logic [31:0] hp;
        do_reset();
        for (int unsigned k = 0; k < 6; k++) begin
            total++; if (bus.cache_address !== 32'(4 * k)) $display("FAIL seq_addr[%0d]: got %h expected %h", k, bus.cache_address, 32'(4 * k)); else passed++;
            if (k == 0) begin
                total++; if (instruction_valid !== 1'b0) $display("FAIL seq_valid0: got %b expected 0", instruction_valid); else passed++;
            end else begin
                hp = 32'(4 * (k - 1));
                total++; if (instruction_valid !== 1'b1) $display("FAIL seq_valid[%0d]: got %b expected 1", k, instruction_valid); else passed++;
                total++; if (pc_out !== hp) $display("FAIL seq_pc[%0d]: got %h expected %h", k, pc_out, hp); else passed++;
                total++; if (instruction !== (32'hC000_0000 ^ hp)) $display("FAIL seq_instr[%0d]: got %h expected %h", k, instruction, 32'hC000_0000 ^ hp); else passed++;
                total++; if (pcIncr !== hp + 32'd4) $display("FAIL seq_incr[%0d]: got %h expected %h", k, pcIncr, hp + 32'd4); else passed++;
            end
            tick();
        end
    endtask

    task automatic test_stall();
        int pushes;
        do_reset();
        stall  = 1'b1;
        pushes = 0;
        #1;
        for (int unsigned i = 0; i < 6; i++) begin
            if (bus.cache_enable && bus.cache_ready) pushes++;
            tick();
        end
        total++; if (pushes !== 4) $display("FAIL stall_pushes: got %0d expected 4", pushes); else passed++;
        total++; if (bus.cache_enable !== 1'b0) $display("FAIL stall_enable: got %b expected 0", bus.cache_enable); else passed++;
        total++; if (bus.cache_address !== 32'h10) $display("FAIL stall_addr: got %h expected 00000010", bus.cache_address); else passed++;
        stall = 1'b0;
        #1;
        for (int unsigned j = 0; j < 4; j++) begin
            total++; if (instruction_valid !== 1'b1) $display("FAIL drain_valid[%0d]: got %b expected 1", j, instruction_valid); else passed++;
            total++; if (pc_out !== 32'(4 * j)) $display("FAIL drain_pc[%0d]: got %h expected %h", j, pc_out, 32'(4 * j)); else passed++;
            tick();
        end
    endtask

    task automatic test_redirect_full();
        do_reset();
        stall = 1'b1;
        repeat (5) tick();
        total++; if (bus.cache_enable !== 1'b0) $display("FAIL full_enable: got %b expected 0", bus.cache_enable); else passed++;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        #1;
        total++; if (instruction_valid !== 1'b0) $display("FAIL redir_valid: got %b expected 0", instruction_valid); else passed++;
        total++; if (bus.cache_address !== 32'h100) $display("FAIL redir_addr: got %h expected 00000100", bus.cache_address); else passed++;
        tick();
        stall = 1'b0;
        #1;
        total++; if (instruction_valid !== 1'b1) $display("FAIL redir_head_valid: got %b expected 1", instruction_valid); else passed++;
        total++; if (pc_out !== 32'h100) $display("FAIL redir_head_pc: got %h expected 00000100", pc_out); else passed++;
    endtask

    task automatic test_miss();
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        tick();
        redirect_valid  = 1'b0;
        bus.cache_ready = 1'b0;
        #1;
        for (int unsigned i = 0; i < 3; i++) begin
            total++; if (bus.cache_address !== 32'h20) $display("FAIL miss_addr[%0d]: got %h expected 00000020", i, bus.cache_address); else passed++;
            total++; if (bus.cache_enable !== 1'b1) $display("FAIL miss_enable[%0d]: got %b expected 1", i, bus.cache_enable); else passed++;
            total++; if (instruction_valid !== 1'b0) $display("FAIL miss_valid[%0d]: got %b expected 0", i, instruction_valid); else passed++;
            tick();
        end
        bus.cache_ready = 1'b1;
        tick();
        total++; if (bus.cache_address !== 32'h24) $display("FAIL hit_addr: got %h expected 00000024", bus.cache_address); else passed++;
        total++; if (pc_out !== 32'h20) $display("FAIL hit_pc: got %h expected 00000020", pc_out); else passed++;
        total++; if (instruction !== 32'hC000_0020) $display("FAIL hit_instr: got %h expected c0000020", instruction); else passed++;
    endtask

    task automatic test_misaligned();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        tick();
        redirect_valid = 1'b0;
        #1;
        total++; if (misaligned_error !== 1'b1) $display("FAIL mis_err: got %b expected 1", misaligned_error); else passed++;
        total++; if (bus.cache_enable !== 1'b0) $display("FAIL mis_enable: got %b expected 0", bus.cache_enable); else passed++;
        tick();
        tick();
        total++; if (misaligned_error !== 1'b1) $display("FAIL mis_sticky: got %b expected 1", misaligned_error); else passed++;
        total++; if (bus.cache_address !== 32'h102) $display("FAIL mis_addr: got %h expected 00000102", bus.cache_address); else passed++;
        total++; if (instruction_valid !== 1'b0) $display("FAIL mis_valid: got %b expected 0", instruction_valid); else passed++;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        #1;
        total++; if (misaligned_error !== 1'b0) $display("FAIL clr_err: got %b expected 0", misaligned_error); else passed++;
        total++; if (bus.cache_enable !== 1'b1) $display("FAIL clr_enable: got %b expected 1", bus.cache_enable); else passed++;
        tick();
        total++; if (pc_out !== 32'h200) $display("FAIL clr_pc: got %h expected 00000200", pc_out); else passed++;
        total++; if (bus.cache_address !== 32'h204) $display("FAIL clr_addr: got %h expected 00000204", bus.cache_address); else passed++;
    endtask

    task automatic test_jump();
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h4000_0000;
        tick();
        redirect_valid = 1'b0;
        tick();
        total++; if (instruction !== 32'h0800_0010) $display("FAIL jmp_instr: got %h expected 08000010", instruction); else passed++;
        total++; if (pcIncr !== 32'h4000_0004) $display("FAIL jmp_incr: got %h expected 40000004", pcIncr); else passed++;
        total++; if (pcJump !== 32'h4000_0040) $display("FAIL jmp_target: got %h expected 40000040", pcJump); else passed++;
        stall = 1'b0;
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        tick();
        total++; if (bus.cache_address !== 32'hFFFF_FFFC) $display("FAIL wrap_addr1: got %h expected fffffffc", bus.cache_address); else passed++;
        tick();
        total++; if (bus.cache_address !== 32'h0) $display("FAIL wrap_addr2: got %h expected 00000000", bus.cache_address); else passed++;
        total++; if (pc_out !== 32'hFFFF_FFFC) $display("FAIL wrap_pc: got %h expected fffffffc", pc_out); else passed++;
        total++; if (pcIncr !== 32'h0) $display("FAIL wrap_incr: got %h expected 00000000", pcIncr); else passed++;
    endtask

    task automatic test_reset_mid_miss();
        bus.cache_ready = 1'b0;
        redirect_valid  = 1'b1;
        redirect_pc     = 32'h80;
        tick();
        redirect_valid = 1'b0;
        tick();
        reset          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        #1;
        total++; if (bus.cache_enable !== 1'b0) $display("FAIL rmid_enable: got %b expected 0", bus.cache_enable); else passed++;
        tick();
        total++; if (bus.cache_address !== 32'h0) $display("FAIL rmid_addr: got %h expected 00000000", bus.cache_address); else passed++;
        reset           = 1'b0;
        redirect_valid  = 1'b0;
        bus.cache_ready = 1'b1;
        #1;
        total++; if (bus.cache_enable !== 1'b1) $display("FAIL rmid_resume: got %b expected 1", bus.cache_enable); else passed++;
        tick();
        total++; if (pc_out !== 32'h0) $display("FAIL rmid_pc: got %h expected 00000000", pc_out); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_full();
        test_miss();
        test_misaligned();
        test_jump();
        test_wrap();
        test_reset_mid_miss();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
